// File: rtl/paper_isa_pkg.sv
// rtl/paper_isa_pkg.sv - shared ISA encodings, state enum and word width for the paper processor
package paper_isa_pkg;

  localparam int WORD_W = 2;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t OP_INC = 2'b00;
  localparam word_t OP_JNO = 2'b01;
  localparam word_t OP_HLT = 2'b10;
  localparam word_t OP_ILL = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    OPERAND,
    HALT
  } state_t;

endpackage

// File: rtl/paper_control_unit_if.sv
// rtl/paper_control_unit_if.sv - instruction ROM bus between control unit and ROM
interface paper_control_unit_if;
  import paper_isa_pkg::*;

  word_t addr;
  word_t data;

  // Control unit drives the address, ROM returns the word in the same cycle
  modport master (output addr, input data);
  modport slave  (input addr, output data);

endinterface

// File: rtl/paper_control_unit.sv
// rtl/paper_control_unit.sv - fetch/decode/execute sequencer for the INC/JNO/HLT ISA
module paper_control_unit
  import paper_isa_pkg::*;
#(
  parameter int ACC_WIDTH = 2,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  paper_control_unit_if.master rom,
  output logic [ACC_WIDTH-1:0] acc,
  output logic                 ovf,
  output logic                 halted,
  output logic                 illegal,
  output logic [CNT_WIDTH-1:0] icount
);

  state_t               state_q, state_d;
  word_t                pc_q, pc_d;
  word_t                ir_q, ir_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic                 illegal_q, illegal_d;
  logic [CNT_WIDTH-1:0] icount_q, icount_d;

  logic [ACC_WIDTH:0]   acc_sum;
  word_t                pc_inc;
  logic [CNT_WIDTH-1:0] icount_inc;

  // Shared incrementers: carry-out of the accumulator feeds ovf, PC wraps 3 -> 0,
  // retired counter sticks at all-ones
  assign acc_sum    = {1'b0, acc_q} + (ACC_WIDTH+1)'(1);
  assign pc_inc     = pc_q + WORD_W'(1);
  assign icount_inc = (icount_q == '1) ? icount_q : icount_q + CNT_WIDTH'(1);

  // Next-state and datapath updates, one case arm per sequencer state
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    illegal_d = illegal_q;
    icount_d  = icount_q;

    unique case (state_q)
      IDLE: begin
        pc_d = '0;
        if (start) state_d = FETCH;
      end
      FETCH: begin
        ir_d    = rom.data;
        pc_d    = pc_inc;
        state_d = EXEC;
      end
      EXEC: begin
        unique case (ir_q)
          OP_INC: begin
            acc_d    = acc_sum[ACC_WIDTH-1:0];
            ovf_d    = acc_sum[ACC_WIDTH];
            icount_d = icount_inc;
            state_d  = FETCH;
          end
          OP_JNO: begin
            state_d = OPERAND;
          end
          OP_HLT: begin
            icount_d = icount_inc;
            state_d  = HALT;
          end
          default: begin
            // Undefined opcode: flag it and stop without retiring anything
            illegal_d = 1'b1;
            state_d   = HALT;
          end
        endcase
      end
      OPERAND: begin
        // The word under the PC is the branch target; skip over it if ovf is set
        pc_d     = ovf_q ? pc_inc : rom.data;
        icount_d = icount_inc;
        state_d  = FETCH;
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous reset that discards any partial instruction
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
      icount_q  <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      illegal_q <= illegal_d;
      icount_q  <= icount_d;
    end
  end

  assign rom.addr = pc_q;
  assign acc      = acc_q;
  assign ovf      = ovf_q;
  assign halted   = (state_q == HALT);
  assign illegal  = illegal_q;
  assign icount   = icount_q;

endmodule

// File: tb/tb_paper_control_unit.sv
// tb/tb_paper_control_unit.sv - randomized self-checking bench with instruction-level reference model
module tb_paper_control_unit;

  localparam int ACC_W = 2;
  localparam int CNT_W = 8;

  logic             clk;
  logic             reset;
  logic             start;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] icount;
  logic [1:0]       rom [4];

  int n_vec;
  int n_err;
  bit cmp_en;

  paper_control_unit_if rom_bus ();
  assign rom_bus.data = rom[rom_bus.addr];

  paper_control_unit #(.ACC_WIDTH(ACC_W), .CNT_WIDTH(CNT_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .rom     (rom_bus),
    .acc     (acc),
    .ovf     (ovf),
    .halted  (halted),
    .illegal (illegal),
    .icount  (icount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 running, 2 stopped.
  // step = cycle index inside the instruction currently in flight.
  int m_mode, m_step, m_op, m_pc, m_acc, m_ovf, m_ill, m_cnt;

  task automatic model_clear();
    m_mode = 0; m_step = 0; m_op = 0; m_pc = 0;
    m_acc = 0; m_ovf = 0; m_ill = 0; m_cnt = 0;
  endtask

  function automatic int sat_inc(int v);
    return (v == (1 << CNT_W) - 1) ? v : v + 1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      model_clear();
    end else if (m_mode == 0) begin
      if (start) begin
        m_mode = 1;
        m_step = 0;
      end
    end else if (m_mode == 1) begin
      if (m_step == 0) begin
        m_op   = int'(rom[m_pc]);
        m_pc   = (m_pc + 1) % 4;
        m_step = 1;
      end else if (m_step == 1) begin
        if (m_op == 0) begin
          m_acc = m_acc + 1;
          if (m_acc == (1 << ACC_W)) begin
            m_acc = 0;
            m_ovf = 1;
          end else begin
            m_ovf = 0;
          end
          m_cnt  = sat_inc(m_cnt);
          m_step = 0;
        end else if (m_op == 1) begin
          m_step = 2;
        end else if (m_op == 2) begin
          m_cnt  = sat_inc(m_cnt);
          m_mode = 2;
        end else begin
          m_ill  = 1;
          m_mode = 2;
        end
      end else begin
        m_pc   = (m_ovf != 0) ? (m_pc + 1) % 4 : int'(rom[m_pc]);
        m_cnt  = sat_inc(m_cnt);
        m_step = 0;
      end
    end
  end

  task automatic chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all DUT outputs against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("addr",    int'(rom_bus.addr), m_pc);
      chk("acc",     int'(acc),          m_acc);
      chk("ovf",     int'(ovf),          m_ovf);
      chk("halted",  int'(halted),       (m_mode == 2) ? 1 : 0);
      chk("illegal", int'(illegal),      m_ill);
      chk("icount",  int'(icount),       m_cnt);
    end
  end

  task automatic load_rom(int w0, int w1, int w2, int w3);
    rom[0] = 2'(w0); rom[1] = 2'(w1); rom[2] = 2'(w2); rom[3] = 2'(w3);
  endtask

  task automatic do_reset(int cycles);
    @(negedge clk);
    reset = 1'b1;
    repeat (cycles) begin
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    reset = 1'b0;
    start = 1'b0;
  endtask

  // Returns after the negedge following the start-sampling edge
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halt(output int n);
    n = 0;
    while (!halted && n < 60) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_addr"},    int'(rom_bus.addr), 0);
    chk({tag, "_acc"},     int'(acc),          0);
    chk({tag, "_ovf"},     int'(ovf),          0);
    chk({tag, "_halted"},  int'(halted),       0);
    chk({tag, "_illegal"}, int'(illegal),      0);
    chk({tag, "_icount"},  int'(icount),       0);
  endtask

  task automatic chk_std_result(string tag);
    chk({tag, "_acc"},    int'(acc),          0);
    chk({tag, "_ovf"},    int'(ovf),          1);
    chk({tag, "_icount"}, int'(icount),       9);
    chk({tag, "_addr"},   int'(rom_bus.addr), 0);
    chk({tag, "_model_icount"}, m_cnt,         9);
  endtask

  initial begin
    int n;
    n_vec  = 0;
    n_err  = 0;
    cmp_en = 1'b0;
    reset  = 1'b1;
    start  = 1'b0;
    load_rom(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    @(posedge clk);
    #1 cmp_en = 1'b1;

    // Reset with random start and ROM contents
    do_reset(2);
    chk_reset_vals("rst");

    // Standard program: INC; JNO 0; HLT
    load_rom(0, 1, 0, 2);
    pulse_start();
    wait_halt(n);
    chk("std_halt_latency", n, 22);
    chk_std_result("std");
    repeat (3) pulse_start();
    chk("std_after_start_icount", int'(icount), 9);
    chk("std_after_start_halted", int'(halted), 1);

    // Immediate HLT
    do_reset(1);
    load_rom(2, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    pulse_start();
    wait_halt(n);
    chk("hlt_latency", n, 2);
    chk("hlt_icount", int'(icount), 1);
    chk("hlt_acc", int'(acc), 0);
    pulse_start();
    pulse_start();
    chk("hlt_after_start_icount", int'(icount), 1);

    // Illegal opcode
    do_reset(1);
    load_rom(3, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    pulse_start();
    wait_halt(n);
    chk("ill_latency", n, 2);
    chk("ill_flag", int'(illegal), 1);
    chk("ill_icount", int'(icount), 0);

    // Reset during the first OPERAND cycle, then a clean rerun
    do_reset(1);
    load_rom(0, 1, 0, 2);
    pulse_start();
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_reset_vals("midrst");
    pulse_start();
    wait_halt(n);
    chk("rerun_halt_latency", n, 22);
    chk_std_result("rerun");

    // All-INC program: PC wraps, start pulses ignored, counter saturates
    do_reset(1);
    load_rom(0, 0, 0, 0);
    pulse_start();
    repeat (8) begin
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    start = 1'b0;
    chk("inc_acc", int'(acc), 0);
    chk("inc_ovf", int'(ovf), 1);
    chk("inc_addr", int'(rom_bus.addr), 0);
    chk("inc_icount", int'(icount), 4);
    chk("inc_halted", int'(halted), 0);
    repeat (600) @(negedge clk);
    chk("inc_icount_sat", int'(icount), 255);
    chk("inc_halted_late", int'(halted), 0);

    // Random programs, starts and resets
    do_reset(1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0)
        load_rom(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      reset = ($urandom_range(0, 39) == 0);
      start = ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
